// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, write-port priority and flattened-bus slicing helper for rf_mp.
package rf_pkg;
  localparam int DW_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF = 2;
  localparam bit WR_PRIO = 1'b1;
  function automatic int slice_lo(int i, int w);
    return i * w;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy vector set by Alloc and cleared by writeback.
// Define RF_BYPASS_EN to hide busy on a register being written in the same cycle.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter int ZERO_R0 = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [1:0]      wen,
  input  logic [AW-1:0]   wa0,
  input  logic [AW-1:0]   wa1,
  input  logic            Alloc,
  input  logic [AW-1:0]   AllocRw,
  input  logic [NRD*AW-1:0] Ra,
  output logic [NRD-1:0]  RdBusy
);
  logic [NREG-1:0] busy, clr, al;
  always_comb begin
    clr = '0;
    al = '0;
    if (wen[0]) clr[wa0] = 1'b1;
    if (wen[1]) clr[wa1] = 1'b1;
    if (Alloc && !(ZERO_R0 != 0 && AllocRw == '0)) al[AllocRw] = 1'b1;
  end
  // a same-cycle alloc outranks the write: the newer producer keeps the register busy
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) busy <= '0;
    else busy <= (busy & ~clr) | al;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = Ra[slice_lo(i, AW) +: AW];
`ifdef RF_BYPASS_EN
    assign RdBusy[i] = busy[a] && !(clr[a] && !al[a]);
`else
    assign RdBusy[i] = busy[a];
`endif
  end
endmodule

// File: rtl/rf_mp.sv
// rf_mp: parametrised multi-port register file, two prioritised write ports and busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module rf_mp
  import rf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter int ZERO_R0 = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WrEn0,
  input  logic [AW-1:0]     Rw0,
  input  logic [DW-1:0]     busW0,
  input  logic              WrEn1,
  input  logic [AW-1:0]     Rw1,
  input  logic [DW-1:0]     busW1,
  input  logic              Alloc,
  input  logic [AW-1:0]     AllocRw,
  input  logic [NRD*AW-1:0] Ra,
  output logic [NRD*DW-1:0] busR,
  output logic [NRD-1:0]    RdBusy
);
  localparam bit Z = ZERO_R0 != 0;
  logic [DW-1:0] rf [NREG];
  logic [1:0] wen;
  logic [AW-1:0] wa [2];
  logic [DW-1:0] wd [2];
  assign wa = '{Rw0, Rw1};
  assign wd = '{busW0, busW1};
  // register 0 is never written, so it reads 0 from reset onwards
  assign wen = {WrEn1 && !(Z && Rw1 == '0), WrEn0 && !(Z && Rw0 == '0)};
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else begin
      if (wen[!WR_PRIO]) rf[wa[!WR_PRIO]] <= wd[!WR_PRIO];
      if (wen[WR_PRIO]) rf[wa[WR_PRIO]] <= wd[WR_PRIO];
    end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = Ra[slice_lo(i, AW) +: AW];
`ifdef RF_BYPASS_EN
    assign busR[slice_lo(i, DW) +: DW] = wen[WR_PRIO] && wa[WR_PRIO] == a ? wd[WR_PRIO] :
                                         wen[!WR_PRIO] && wa[!WR_PRIO] == a ? wd[!WR_PRIO] : rf[a];
`else
    assign busR[slice_lo(i, DW) +: DW] = rf[a];
`endif
  end
  rf_scoreboard #(.NREG(NREG), .NRD(NRD), .ZERO_R0(ZERO_R0)) u_sb (
    .Clk(Clk), .Rst_n(Rst_n), .wen(wen), .wa0(Rw0), .wa1(Rw1),
    .Alloc(Alloc), .AllocRw(AllocRw), .Ra(Ra), .RdBusy(RdBusy)
  );
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: directed and random checks of rf_mp against an array/scoreboard reference model.
module tb_rf_mp;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic we0, we1, al;
  logic [4:0] rw0, rw1, arw;
  logic [31:0] d0, d1;
  logic [9:0] ra;
  logic [63:0] busr;
  logic [1:0] rdb;
  rf_mp dut (
    .Clk(clk), .Rst_n(rst_n), .WrEn0(we0), .Rw0(rw0), .busW0(d0), .WrEn1(we1), .Rw1(rw1),
    .busW1(d1), .Alloc(al), .AllocRw(arw), .Ra(ra), .busR(busr), .RdBusy(rdb)
  );
  logic pwe0, pwe1, pal;
  logic [2:0] prw0, prw1, parw;
  logic [15:0] pd0, pd1;
  logic [11:0] pra;
  logic [63:0] pbusr;
  logic [3:0] prdb;
  rf_mp #(.DW(16), .NREG(8), .NRD(4)) dut_p (
    .Clk(clk), .Rst_n(rst_n), .WrEn0(pwe0), .Rw0(prw0), .busW0(pd0), .WrEn1(pwe1), .Rw1(prw1),
    .busW1(pd1), .Alloc(pal), .AllocRw(parw), .Ra(pra), .busR(pbusr), .RdBusy(prdb)
  );
  int checks = 0, failures = 0;
  logic [31:0] mem [32];
  bit bsy [32];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(int a);
    if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (we1 && rw1 == a) return d1;
    if (we0 && rw0 == a) return d0;
`endif
    return mem[a];
  endfunction

  function automatic bit exp_busy(int a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (((we1 && rw1 == a) || (we0 && rw0 == a)) && !(al && arw == a)) return 1'b0;
`endif
    return bsy[a];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      mem[r] = 32'h0;
      bsy[r] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (we0 && rw0 != 0) begin mem[rw0] = d0; bsy[rw0] = 1'b0; end
    if (we1 && rw1 != 0) begin mem[rw1] = d1; bsy[rw1] = 1'b0; end
    if (al && arw != 0) bsy[arw] = 1'b1;
  endtask

  task automatic set(bit w0_, int a0, logic [31:0] x0, bit w1_, int a1, logic [31:0] x1,
                     bit al_, int aa, int r0_, int r1_);
    we0 = w0_; rw0 = 5'(a0); d0 = x0;
    we1 = w1_; rw1 = 5'(a1); d1 = x1;
    al = al_; arw = 5'(aa);
    ra = {5'(r1_), 5'(r0_)};
  endtask

  task automatic half(string tag);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.busR%0d", tag, i), busr[i*32 +: 32], exp_data(int'(ra[i*5 +: 5])));
      chk($sformatf("%s.RdBusy%0d", tag, i), rdb[i], exp_busy(int'(ra[i*5 +: 5])));
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(string tag);
    half(tag);
    edge_();
  endtask

  initial begin
    model_clear();
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    {pwe0, pwe1, pal, prw0, prw1, parw, pd0, pd1, pra} = '0;
    #2 chk("rst_async_busR", busr, 64'h0);
    chk("rst_async_RdBusy", rdb, 2'b00);
    #10 rst_n = 1'b1;
    @(posedge clk) #1;
    cyc("after_rst");
    // preload then reset mid-cycle with a write in flight
    set(1, 1, 32'hCAFE0001, 1, 2, 32'hCAFE0002, 1, 6, 1, 6);
    cyc("preload");
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    cyc("preload_rd");
    set(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 6);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_busR", busr, 64'h0);
    chk("rst_mid_RdBusy", rdb, 2'b00);
    model_clear();
    @(posedge clk) #1;
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    chk("rst_write_lost", busr, 64'h0);
    #2 rst_n = 1'b1;
    @(posedge clk) #1;
    cyc("post_rst");
    // dual-write collision: port 1 wins
    set(1, 5, 32'h1111, 1, 5, 32'h2222, 0, 0, 5, 5);
    cyc("collide");
    chk("collide_lit", busr[31:0], 32'h2222);
    // register 0 ignores writes and allocs
    set(1, 0, 32'hDEAD, 0, 0, 0, 1, 0, 0, 0);
    cyc("zero");
    chk("zero_lit_busR", busr, 64'h0);
    chk("zero_lit_RdBusy", rdb, 2'b00);
    // scoreboard sequence on r8
    set(0, 0, 0, 0, 0, 0, 1, 8, 8, 8);
    cyc("sb_alloc");
    chk("sb_busy_set", rdb[0], 1'b1);
    set(0, 0, 0, 0, 0, 0, 0, 0, 8, 8);
    cyc("sb_hold");
    chk("sb_busy_hold", rdb[0], 1'b1);
    set(1, 8, 32'h000A, 0, 0, 0, 0, 0, 8, 8);
    cyc("sb_write");
    chk("sb_busy_clr", rdb[0], 1'b0);
    chk("sb_data", busr[31:0], 32'h000A);
    set(0, 0, 0, 1, 8, 32'h0005, 1, 8, 8, 8);
    cyc("sb_alloc_write");
    chk("sb_alloc_wins", rdb[0], 1'b1);
    chk("sb_alloc_write_data", busr[31:0], 32'h0005);
    // same-cycle visibility of a write to r19
    set(1, 19, 32'h0077, 0, 0, 0, 0, 0, 19, 3);
    cyc("byp_old");
    set(0, 0, 0, 1, 19, 32'h0002, 0, 0, 19, 3);
    half("byp");
`ifdef RF_BYPASS_EN
    chk("byp_lit", busr[31:0], 32'h0002);
`else
    chk("byp_lit", busr[31:0], 32'h0077);
`endif
    chk("byp_busy_lit", rdb[0], 1'b0);
    edge_();
    // random traffic with collision-prone addresses
    for (int n = 0; n < 400; n++) begin
      int m;
      m = ($urandom_range(0, 1) != 0) ? 3 : 31;
      set(1'($urandom), $urandom_range(0, m), $urandom, 1'($urandom), $urandom_range(0, m), $urandom,
          1'($urandom), $urandom_range(0, m), $urandom_range(0, m), $urandom_range(0, 31));
      cyc("rand");
    end
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // narrow/deep-port instance: four independent reads
    pwe0 = 1'b1; prw0 = 3'd1; pd0 = 16'h000A; pwe1 = 1'b1; prw1 = 3'd2; pd1 = 16'h000B;
    @(posedge clk) #1;
    prw0 = 3'd3; pd0 = 16'h000C; prw1 = 3'd4; pd1 = 16'h000D;
    @(posedge clk) #1;
    pwe0 = 1'b0; pwe1 = 1'b0;
    pra = {3'd4, 3'd3, 3'd2, 3'd1};
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("p_busR%0d", i), pbusr[i*16 +: 16], 64'(16'h000A + i));
    chk("p_RdBusy", prdb, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
